mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (requester 1) and mem_access (requester 2).
//  Registered fixed-priority arbiter (data first) with a fetch-starvation guard.
//  Sequences each transfer on the downstream port with variable wait states and a timeout.
//  Returns per-requester ready/response and fetch/data stall flags to the pipeline.
// PARAMETERS
//  DATA_W           64  data width, all data buses
//  ADDR_W           64  address width, all address buses
//  TIMEOUT          16  max BUSY cycles awaiting PREADY before error completion (>=2)
//  MAX_DATA_STREAK   4  consecutive data grants allowed while fetch is pending
// PORTS
//  CLK        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  HTRANS_1   in   1       fetch request; held with HADDR_1 stable until HREADY_1
//  HADDR_1    in   ADDR_W  fetch address
//  HRDATA_1   out  DATA_W  fetch read data, valid with HREADY_1
//  HREADY_1   out  1       one-cycle fetch completion pulse
//  HRESP_1    out  1       fetch error, valid with HREADY_1
//  HTRANS_2   in   1       data request; held with addr/write/wdata stable until HREADY_2
//  HADDR_2    in   ADDR_W  data address
//  HWRITE_2   in   1       1 = write
//  HWDATA_2   in   DATA_W  write data
//  HRDATA_2   out  DATA_W  data read data, valid with HREADY_2
//  HREADY_2   out  1       one-cycle data completion pulse
//  HRESP_2    out  1       data error, valid with HREADY_2
//  PSEL       out  1       downstream transfer active
//  PADDR      out  ADDR_W  downstream address
//  PWRITE     out  1       downstream write strobe
//  PWDATA     out  DATA_W  downstream write data
//  PRDATA     in   DATA_W  downstream read data, sampled when PSEL & PREADY
//  PREADY     in   1       downstream completion
//  stall_1    out  1       HTRANS_1 & ~HREADY_1
//  stall_2    out  1       HTRANS_2 & ~HREADY_2
// BEHAVIOUR
//  Reset (synchronous, active-high; overrides any transfer): state IDLE.
//   PSEL, PWRITE, HREADY_x, HRESP_x, streak and timeout counters = 0.
//   PADDR, PWDATA, HRDATA_x = 0.
//  FSM states: IDLE, BUSY, DONE. The owner register records the granted requester.
//   IDLE: if any HTRANS_x, choose the owner and latch address/write/wdata into the P* registers.
//     Next state BUSY; otherwise stay IDLE.
//   Arbitration: requester 2 wins unless HTRANS_1 && streak == MAX_DATA_STREAK; then requester 1 wins.
//   Streak counter: +1 on each grant to requester 2 while HTRANS_1 is high;
//     cleared on a grant to requester 1 or when HTRANS_1 is low at grant time; saturates.
//   Fetch is read-only: PWRITE = 0 and PWDATA = 0 on requester-1 grants.
//   BUSY: PSEL = 1 and the P* outputs are held. Timeout counter increments each BUSY cycle.
//     PREADY = 1: latch PRDATA into HRDATA_owner (0 for writes), HRESP = 0, next state DONE.
//     Counter reaches TIMEOUT-1 without PREADY: HRDATA_owner = 0, HRESP_owner = 1, next state DONE.
//     PREADY on the last allowed cycle wins over timeout.
//   DONE: PSEL = 0. HREADY_owner = 1 for exactly this cycle; the other HREADY stays 0. Next state IDLE.
//     HRDATA_x and HRESP_x hold until that requester's next completion.
//  Latency: request in IDLE at cycle n -> PSEL at n+1 -> HREADY at n+1+W+1 (W = wait cycles, PREADY at n+1+W).
//   Zero-wait throughput is one transfer per 3 cycles.
//  A request still high in the IDLE cycle after HREADY counts as a new transfer (back-to-back).
//  HTRANS drop during BUSY: the transfer still completes. The requester must not drop it (protocol violation).
//  PREADY outside BUSY is ignored.
//  Simultaneous requests in IDLE: exactly one grant; the loser's stall stays high.
// TESTING
//  T1 reset: assert reset mid-BUSY (PREADY=0) -> next cycle IDLE, PSEL=0, all HREADY/HRESP=0.
//  T2 single fetch read, PREADY tied 1:
//     HTRANS_1 at n, HADDR_1=0x80 -> PSEL at n+1 with PADDR=0x80;
//     HREADY_1 at n+2 with HRDATA_1 = PRDATA(0xDEADBEEF); stall_1 high at n and n+1 only.
//  T3 data write, PREADY at 3rd BUSY cycle:
//     HADDR_2=0x100, HWDATA_2=0x55 -> PWRITE=1 and PWDATA=0x55 for 3 cycles; HREADY_2 one cycle later, HRESP_2=0.
//  T4 contention, both requests held continuously, MAX_DATA_STREAK=4 -> grant order 2,2,2,2,1,2,2,2,2,1.
//  T5 timeout, PREADY stuck 0, TIMEOUT=16 -> PSEL for 16 cycles, then HREADY_2=1, HRESP_2=1, HRDATA_2=0.
//     Next data transfer with PREADY=1 returns HRESP_2=0.
//  T6 back-to-back: HTRANS_1 held through HREADY_1 -> second PSEL exactly 2 cycles after the first HREADY_1 cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port (1), data port (2), downstream
// memory port (P*) and the pipeline stall flags.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Fetch requester
  logic              HTRANS_1;
  logic [ADDR_W-1:0] HADDR_1;
  logic [DATA_W-1:0] HRDATA_1;
  logic              HREADY_1;
  logic              HRESP_1;
  // Data requester
  logic              HTRANS_2;
  logic [ADDR_W-1:0] HADDR_2;
  logic              HWRITE_2;
  logic [DATA_W-1:0] HWDATA_2;
  logic [DATA_W-1:0] HRDATA_2;
  logic              HREADY_2;
  logic              HRESP_2;
  // Downstream memory port
  logic              PSEL;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  // Pipeline stall flags
  logic              stall_1;
  logic              stall_2;

  // Arbiter view
  modport slave (
    input  HTRANS_1, HADDR_1,
    output HRDATA_1, HREADY_1, HRESP_1,
    input  HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
    output HRDATA_2, HREADY_2, HRESP_2,
    output PSEL, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY,
    output stall_1, stall_2
  );

  // Environment view (requesters + memory)
  modport master (
    output HTRANS_1, HADDR_1,
    input  HRDATA_1, HREADY_1, HRESP_1,
    output HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
    input  HRDATA_2, HREADY_2, HRESP_2,
    input  PSEL, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY,
    input  stall_1, stall_2
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (1) and
// data access (2). Registered fixed-priority arbitration (data first) with
// a fetch-starvation guard, wait-state sequencing and a BUSY timeout.
module mem_arbiter #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 64,
  parameter int TIMEOUT         = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic          CLK,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t              state_q,   state_d;
  owner_t              owner_q,   owner_d;
  logic [STREAK_W-1:0] streak_q,  streak_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [ADDR_W-1:0]   paddr_q,   paddr_d;
  logic                pwrite_q,  pwrite_d;
  logic [DATA_W-1:0]   pwdata_q,  pwdata_d;
  logic [DATA_W-1:0]   hrdata1_q, hrdata1_d;
  logic                hresp1_q,  hresp1_d;
  logic [DATA_W-1:0]   hrdata2_q, hrdata2_d;
  logic                hresp2_q,  hresp2_d;

  logic                grant_fetch;
  logic                complete;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_data;
  logic                hready1, hready2;

  // State and datapath registers; synchronous reset overrides everything
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      streak_q  <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      hrdata1_q <= '0;
      hresp1_q  <= 1'b0;
      hrdata2_q <= '0;
      hresp2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      hrdata1_q <= hrdata1_d;
      hresp1_q  <= hresp1_d;
      hrdata2_q <= hrdata2_d;
      hresp2_q  <= hresp2_d;
    end
  end

  // Next-state: arbitration in IDLE, wait/timeout handling in BUSY
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    hrdata1_d   = hrdata1_q;
    hresp1_d    = hresp1_q;
    hrdata2_d   = hrdata2_q;
    hresp2_d    = hresp2_q;
    grant_fetch = 1'b0;
    complete    = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.HTRANS_1 || bus.HTRANS_2) begin
          // Fetch wins when alone, or when data has had its full streak
          grant_fetch = bus.HTRANS_1 &&
                        (!bus.HTRANS_2 || streak_q == STREAK_W'(MAX_DATA_STREAK));
          cnt_d   = '0;
          state_d = BUSY;
          if (grant_fetch) begin
            owner_d  = OWN_FETCH;
            paddr_d  = bus.HADDR_1;
            pwrite_d = 1'b0;
            pwdata_d = '0;
            streak_d = '0;
          end else begin
            owner_d  = OWN_DATA;
            paddr_d  = bus.HADDR_2;
            pwrite_d = bus.HWRITE_2;
            pwdata_d = bus.HWDATA_2;
            if (!bus.HTRANS_1) begin
              streak_d = '0;
            end else if (streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // PREADY takes precedence over an expiring timeout
        if (bus.PREADY) begin
          complete  = 1'b1;
          resp_data = pwrite_q ? '0 : bus.PRDATA;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          complete = 1'b1;
          resp_err = 1'b1;
        end
        if (complete) begin
          cnt_d   = '0;
          state_d = DONE;
          if (owner_q == OWN_FETCH) begin
            hrdata1_d = resp_data;
            hresp1_d  = resp_err;
          end else begin
            hrdata2_d = resp_data;
            hresp2_d  = resp_err;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hready1 = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign hready2 = (state_q == DONE) && (owner_q == OWN_DATA);

  assign bus.PSEL     = (state_q == BUSY);
  assign bus.PADDR    = paddr_q;
  assign bus.PWRITE   = pwrite_q;
  assign bus.PWDATA   = pwdata_q;
  assign bus.HREADY_1 = hready1;
  assign bus.HRESP_1  = hresp1_q;
  assign bus.HRDATA_1 = hrdata1_q;
  assign bus.HREADY_2 = hready2;
  assign bus.HRESP_2  = hresp2_q;
  assign bus.HRDATA_2 = hrdata2_q;
  assign bus.stall_1  = bus.HTRANS_1 & ~hready1;
  assign bus.stall_2  = bus.HTRANS_2 & ~hready2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single transfers,
// hand sequences for reset, contention, timeout and back-to-back.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_arbiter #(
    .DATA_W(64), .ADDR_W(64), .TIMEOUT(16), .MAX_DATA_STREAK(4)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        psel;
    logic [63:0] paddr;
    logic        pwrite;
    logic [63:0] pwdata;
    logic        hr1;
    logic        rs1;
    logic [63:0] d1;
    logic        hr2;
    logic        rs2;
    logic [63:0] d2;
    logic        st1;
    logic        st2;
  } out_t;

  typedef struct {
    logic        t1;
    logic [63:0] a1;
    logic        t2;
    logic [63:0] a2;
    logic        w2;
    logic [63:0] wd2;
    logic [63:0] prd;
    logic        prdy;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic t1, input logic [63:0] a1, input logic t2,
                     input logic [63:0] a2, input logic w2, input logic [63:0] wd2,
                     input logic [63:0] prd, input logic prdy,
                     input logic psel, input logic [63:0] paddr, input logic pw,
                     input logic [63:0] pwd,
                     input logic r1, input logic s1, input logic [63:0] d1,
                     input logic r2, input logic s2, input logic [63:0] d2,
                     input logic st1, input logic st2);
    vec_t v;
    v.t1 = t1; v.a1 = a1; v.t2 = t2; v.a2 = a2; v.w2 = w2; v.wd2 = wd2;
    v.prd = prd; v.prdy = prdy;
    v.exp = '{psel, paddr, pw, pwd, r1, s1, d1, r2, s2, d2, st1, st2};
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    return '{bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA,
             bus.HREADY_1, bus.HRESP_1, bus.HRDATA_1,
             bus.HREADY_2, bus.HRESP_2, bus.HRDATA_2,
             bus.stall_1, bus.stall_2};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.HTRANS_1 = 1'b0; bus.HADDR_1 = '0;
    bus.HTRANS_2 = 1'b0; bus.HADDR_2 = '0; bus.HWRITE_2 = 1'b0; bus.HWDATA_2 = '0;
    bus.PRDATA = '0; bus.PREADY = 1'b0;
  endtask

  // Runs one transfer already requested in IDLE; PREADY is raised on BUSY
  // cycle pready_at (0 = never). Returns in the completion cycle.
  task automatic run_xfer(input int pready_at, output int nsel, output bit got);
    nsel = 0;
    got  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.PSEL) begin
        nsel++;
        bus.PREADY = (pready_at != 0) && (nsel >= pready_at);
      end else begin
        bus.PREADY = 1'b0;
      end
      if (bus.HREADY_1 || bus.HREADY_2) begin
        got = 1'b1;
        bus.HTRANS_1 = 1'b0;
        bus.HTRANS_2 = 1'b0;
        bus.PREADY   = 1'b0;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nsel;
    bit   got;
    int   order[10];
    int   ngr;
    int   c_rdy, c_sel2, nrise;
    logic prev;

    // Vectors: inputs | psel paddr pwrite pwdata | hr1 rs1 d1 | hr2 rs2 d2 | st1 st2
    // Fetch read, PREADY tied high
    add(1, 'h80, 0, 0, 0, 0, 'hDEADBEEF, 1,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0);
    add(1, 'h80, 0, 0, 0, 0, 'hDEADBEEF, 1,  1, 'h80, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0);
    add(1, 'h80, 0, 0, 0, 0, 'hDEADBEEF, 1,  0, 'h80, 0, 0,  1, 0, 'hDEADBEEF,  0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,              0, 'h80, 0, 0,  0, 0, 'hDEADBEEF,  0, 0, 0,  0, 0);
    // Data read, zero wait; PREADY during DONE must be ignored
    add(0, 0, 1, 'h200, 0, 0, 'hCAFE, 1,     0, 'h80, 0, 0,  0, 0, 'hDEADBEEF,  0, 0, 0,  0, 1);
    add(0, 0, 1, 'h200, 0, 0, 'hCAFE, 1,     1, 'h200, 0, 0, 0, 0, 'hDEADBEEF,  0, 0, 0,  0, 1);
    add(0, 0, 0, 0, 0, 0, 'hCAFE, 1,         0, 'h200, 0, 0, 0, 0, 'hDEADBEEF,  1, 0, 'hCAFE,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,              0, 'h200, 0, 0, 0, 0, 'hDEADBEEF,  0, 0, 'hCAFE,  0, 0);
    // Data write, PREADY on third BUSY cycle; write returns zero data
    add(0, 0, 1, 'h100, 1, 'h55, 'h1234, 0,  0, 'h200, 0, 0,    0, 0, 'hDEADBEEF,  0, 0, 'hCAFE,  0, 1);
    add(0, 0, 1, 'h100, 1, 'h55, 'h1234, 0,  1, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  0, 0, 'hCAFE,  0, 1);
    add(0, 0, 1, 'h100, 1, 'h55, 'h1234, 0,  1, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  0, 0, 'hCAFE,  0, 1);
    add(0, 0, 1, 'h100, 1, 'h55, 'h1234, 1,  1, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  0, 0, 'hCAFE,  0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,              0, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  1, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 0, 'hFFFF, 1,         0, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  0, 0, 0,  0, 0);
    // Simultaneous requests: data wins, fetch stalls, then fetch is served
    add(1, 'h300, 1, 'h400, 0, 0, 'h77, 1,   0, 'h100, 1, 'h55, 0, 0, 'hDEADBEEF,  0, 0, 0,  1, 1);
    add(1, 'h300, 1, 'h400, 0, 0, 'h77, 1,   1, 'h400, 0, 0,    0, 0, 'hDEADBEEF,  0, 0, 0,  1, 1);
    add(1, 'h300, 0, 0, 0, 0, 'h77, 1,       0, 'h400, 0, 0,    0, 0, 'hDEADBEEF,  1, 0, 'h77,  1, 0);
    add(1, 'h300, 0, 0, 0, 0, 'h88, 1,       0, 'h400, 0, 0,    0, 0, 'hDEADBEEF,  0, 0, 'h77,  1, 0);
    add(1, 'h300, 0, 0, 0, 0, 'h88, 1,       1, 'h300, 0, 0,    0, 0, 'hDEADBEEF,  0, 0, 'h77,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,              0, 'h300, 0, 0,    1, 0, 'h88,  0, 0, 'h77,  0, 0);

    // Power-up reset
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Table
    foreach (vecs[i]) begin
      bus.HTRANS_1 = vecs[i].t1;  bus.HADDR_1 = vecs[i].a1;
      bus.HTRANS_2 = vecs[i].t2;  bus.HADDR_2 = vecs[i].a2;
      bus.HWRITE_2 = vecs[i].w2;  bus.HWDATA_2 = vecs[i].wd2;
      bus.PRDATA   = vecs[i].prd; bus.PREADY = vecs[i].prdy;
      #1;
      chk($sformatf("vec%0d", i), 256'(sample()), 256'(vecs[i].exp));
      tick();
    end

    // Reset in the middle of a stalled BUSY
    idle_inputs();
    bus.HTRANS_2 = 1'b1; bus.HADDR_2 = 'h500;
    tick();
    chk("t1_busy_psel", 256'(bus.PSEL), 256'(1));
    tick();
    reset = 1'b1;
    bus.HTRANS_2 = 1'b0;
    tick();
    reset = 1'b0;
    chk("t1_psel",   256'(bus.PSEL), 256'(0));
    chk("t1_ready",  256'({bus.HREADY_1, bus.HREADY_2}), 256'(0));
    chk("t1_resp",   256'({bus.HRESP_1, bus.HRESP_2}), 256'(0));
    chk("t1_rdata",  256'({bus.HRDATA_1, bus.HRDATA_2}), 256'(0));
    chk("t1_paddr",  256'(bus.PADDR), 256'(0));
    tick();
    chk("t1_idle",   256'(bus.PSEL), 256'(0));

    // Contention: both held, starvation guard every fifth grant
    bus.HTRANS_1 = 1'b1; bus.HADDR_1 = 'h1000;
    bus.HTRANS_2 = 1'b1; bus.HADDR_2 = 'h2000; bus.HWRITE_2 = 1'b0;
    bus.PREADY = 1'b1; bus.PRDATA = 'h42;
    foreach (order[i]) order[i] = 0;
    ngr = 0;
    for (int i = 0; i < 60 && ngr < 10; i++) begin
      if (bus.PSEL) begin
        order[ngr] = (bus.PADDR == 64'h1000) ? 1 : 2;
        ngr++;
      end
      tick();
    end
    bus.HTRANS_1 = 1'b0; bus.HTRANS_2 = 1'b0; bus.PREADY = 1'b0;
    chk("t4_grants", 256'(ngr), 256'(10));
    chk("t4_last_hready1", 256'(bus.HREADY_1), 256'(1));
    chk("t4_last_hrdata1", 256'(bus.HRDATA_1), 256'('h42));
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_order%0d", i), 256'(order[i]), 256'((i % 5 == 4) ? 1 : 2));
    tick();

    // Timeout with PREADY stuck low
    bus.HTRANS_2 = 1'b1; bus.HADDR_2 = 'h600; bus.HWRITE_2 = 1'b0;
    bus.PRDATA = 'h99;
    run_xfer(0, nsel, got);
    chk("t5_done",    256'(got), 256'(1));
    chk("t5_nsel",    256'(nsel), 256'(16));
    chk("t5_hready2", 256'({bus.HREADY_1, bus.HREADY_2}), 256'(1));
    chk("t5_hresp2",  256'(bus.HRESP_2), 256'(1));
    chk("t5_hrdata2", 256'(bus.HRDATA_2), 256'(0));
    tick();
    // PREADY on the last allowed cycle wins over timeout
    bus.HTRANS_2 = 1'b1; bus.HADDR_2 = 'h608;
    run_xfer(16, nsel, got);
    chk("t5_last_done",  256'(got), 256'(1));
    chk("t5_last_nsel",  256'(nsel), 256'(16));
    chk("t5_last_hresp", 256'(bus.HRESP_2), 256'(0));
    chk("t5_last_data",  256'(bus.HRDATA_2), 256'('h99));
    tick();
    // Ordinary transfer after an error
    bus.HTRANS_2 = 1'b1; bus.HADDR_2 = 'h610; bus.PRDATA = 'hABC;
    run_xfer(1, nsel, got);
    chk("t5_next_nsel",  256'(nsel), 256'(1));
    chk("t5_next_hresp", 256'(bus.HRESP_2), 256'(0));
    chk("t5_next_data",  256'(bus.HRDATA_2), 256'('hABC));
    tick();

    // Back-to-back fetch with HTRANS_1 held through HREADY_1
    bus.HTRANS_1 = 1'b1; bus.HADDR_1 = 'h80;
    bus.PREADY = 1'b1; bus.PRDATA = 'h5;
    c_rdy = -1; c_sel2 = -1; nrise = 0; prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.PSEL && !prev) begin
        nrise++;
        if (nrise == 2) c_sel2 = c;
      end
      prev = bus.PSEL;
      if (bus.HREADY_1 && c_rdy < 0) c_rdy = c;
      if (c_sel2 >= 0) break;
      tick();
    end
    bus.HTRANS_1 = 1'b0;
    chk("t6_first_ready", 256'(c_rdy), 256'(2));
    chk("t6_second_psel", 256'(c_sel2), 256'(4));
    tick();
    tick();
    bus.PREADY = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
